vga_rect_engine: RTL

VGA_RECT_ENGINE -- requirements
Module: vga_rect_engine

---
 rtl/vga_pkg.sv | 46 ++++
 rtl/vga_timing.sv | 76 +++++++
 rtl/vga_rect_engine.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA rectangle engine:
//   - default 640x480@60 timing constants (pixels / lines)
//   - default rectangle count and coordinate width
//   - register map offsets and control-word bit positions
//   - 3-3-2 colour type and the rectangle register address helper
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_NUM_RECT = 4;
    localparam int unsigned DEF_CW       = 10;

    // Per-rectangle register block: five consecutive addresses.
    localparam int unsigned REGS_PER_RECT = 5;
    localparam int unsigned OFS_X0        = 0;
    localparam int unsigned OFS_X1        = 1;
    localparam int unsigned OFS_Y0        = 2;
    localparam int unsigned OFS_Y1        = 3;
    localparam int unsigned OFS_CTRL      = 4;
    localparam logic [5:0]  ADDR_BG       = 6'd63;

    // Control word layout: {BLINK[9], EN[8], COLOUR[7:0]}.
    localparam int unsigned CTRL_EN_BIT    = 8;
    localparam int unsigned CTRL_BLINK_BIT = 9;

    typedef struct packed {
        logic [2:0] red;
        logic [2:0] green;
        logic [1:0] blue;
    } rgb332_t;

    function automatic logic [5:0] rect_addr(input int unsigned idx,
                                             input int unsigned ofs);
        return 6'(idx * REGS_PER_RECT + ofs);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Pixel-enable generator and raster counters for the VGA rectangle engine.
// The pixel enable toggles every clk cycle (25 MHz from 50 MHz); X/Y only
// advance on enable.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   x, y        : current raster position
//   active      : position lies inside the visible area
//   h_sync      : horizontal sync, low during the sync interval
//   v_sync      : vertical sync, low during the sync lines
//   frame_wrap  : single clk cycle in which X and Y both wrap to 0 next edge
// ---------------------------------------------------------------------------
module vga_timing import vga_pkg::*; #(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned CW       = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          active,
    output logic          h_sync,
    output logic          v_sync,
    output logic          frame_wrap
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic pix_en;
    logic x_last;
    logic y_last;

    assign x_last = (x == H_LAST);
    assign y_last = (y == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_en <= 1'b0;
            x      <= '0;
            y      <= '0;
        end else begin
            pix_en <= ~pix_en;
            if (pix_en) begin
                if (x_last) begin
                    x <= '0;
                    y <= y_last ? '0 : y + CW'(1);
                end else begin
                    x <= x + CW'(1);
                end
            end
        end
    end

    assign active     = (x < H_VIS) && (y < V_VIS);
    assign h_sync     = !((x >= HS_START) && (x < HS_END));
    assign v_sync     = !((y >= VS_START) && (y < VS_END));
    assign frame_wrap = pix_en && x_last && y_last;

endmodule

// File: rtl/vga_rect_engine.sv
// ---------------------------------------------------------------------------
// vga_rect_engine
// Draws up to NUM_RECT solid, prioritised rectangles over a background
// colour on a VGA raster. Registers are written into a shadow set and
// become active atomically at the frame wrap.
//   CLK_50, RESET_N      : 50 MHz clock, asynchronous active-low reset
//   WR_VALID / WR_READY  : register write handshake (READY low in copy cycle)
//   WR_ADDR, WR_DATA     : register address (5 per rectangle, 63 = bg)
//   RED, GREEN, BLUE     : 3-3-2 pixel colour, 0 outside the visible area
//   h_sync, v_sync       : negative-polarity syncs, aligned with colour
//   FRAME_START          : one-cycle pulse in the shadow-to-active copy cycle
// Optional build macro VGA_BLINK_EN: adds a BLINK control bit (bit 9);
// blinking rectangles only hit while a 6-bit frame counter MSB is set.
// ---------------------------------------------------------------------------
module vga_rect_engine import vga_pkg::*; #(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned NUM_RECT = DEF_NUM_RECT,
    parameter int unsigned CW       = DEF_CW
) (
    input  logic        CLK_50,
    input  logic        RESET_N,
    input  logic        WR_VALID,
    output logic        WR_READY,
    input  logic [5:0]  WR_ADDR,
    input  logic [15:0] WR_DATA,
    output logic [2:0]  RED,
    output logic [2:0]  GREEN,
    output logic [1:0]  BLUE,
    output logic        h_sync,
    output logic        v_sync,
    output logic        FRAME_START
);

    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          active;
    logic          hs_raw;
    logic          vs_raw;
    logic          frame_wrap;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CW       (CW)
    ) u_timing (
        .clk        (CLK_50),
        .rst_n      (RESET_N),
        .x          (x),
        .y          (y),
        .active     (active),
        .h_sync     (hs_raw),
        .v_sync     (vs_raw),
        .frame_wrap (frame_wrap)
    );

    // ------------------------------------------------------------------
    // Write handshake
    // ------------------------------------------------------------------
    logic ready_q;
    logic wr_fire;

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) ready_q <= 1'b0;
        else          ready_q <= 1'b1;
    end

    // Writes are blocked in the copy cycle so shadow and active never race.
    assign WR_READY    = ready_q && !frame_wrap;
    assign wr_fire     = WR_VALID && WR_READY;
    assign FRAME_START = frame_wrap;

    // ------------------------------------------------------------------
    // Shadow and active register sets
    // ------------------------------------------------------------------
    logic [CW-1:0] x0_sh  [NUM_RECT];
    logic [CW-1:0] x1_sh  [NUM_RECT];
    logic [CW-1:0] y0_sh  [NUM_RECT];
    logic [CW-1:0] y1_sh  [NUM_RECT];
    logic          en_sh  [NUM_RECT];
    rgb332_t       col_sh [NUM_RECT];
    rgb332_t       bg_sh;

    logic [CW-1:0] x0_act  [NUM_RECT];
    logic [CW-1:0] x1_act  [NUM_RECT];
    logic [CW-1:0] y0_act  [NUM_RECT];
    logic [CW-1:0] y1_act  [NUM_RECT];
    logic          en_act  [NUM_RECT];
    rgb332_t       col_act [NUM_RECT];
    rgb332_t       bg_act;

`ifdef VGA_BLINK_EN
    logic       blink_sh  [NUM_RECT];
    logic       blink_act [NUM_RECT];
    logic [5:0] frame_cnt;
`endif

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned i = 0; i < NUM_RECT; i++) begin
                x0_sh[i]  <= '0;
                x1_sh[i]  <= '0;
                y0_sh[i]  <= '0;
                y1_sh[i]  <= '0;
                en_sh[i]  <= 1'b0;
                col_sh[i] <= '0;
`ifdef VGA_BLINK_EN
                blink_sh[i] <= 1'b0;
`endif
            end
            bg_sh <= '0;
        end else if (wr_fire) begin
            for (int unsigned i = 0; i < NUM_RECT; i++) begin
                if (WR_ADDR == rect_addr(i, OFS_X0)) x0_sh[i] <= WR_DATA[CW-1:0];
                if (WR_ADDR == rect_addr(i, OFS_X1)) x1_sh[i] <= WR_DATA[CW-1:0];
                if (WR_ADDR == rect_addr(i, OFS_Y0)) y0_sh[i] <= WR_DATA[CW-1:0];
                if (WR_ADDR == rect_addr(i, OFS_Y1)) y1_sh[i] <= WR_DATA[CW-1:0];
                if (WR_ADDR == rect_addr(i, OFS_CTRL)) begin
                    en_sh[i]  <= WR_DATA[CTRL_EN_BIT];
                    col_sh[i] <= rgb332_t'(WR_DATA[7:0]);
`ifdef VGA_BLINK_EN
                    blink_sh[i] <= WR_DATA[CTRL_BLINK_BIT];
`endif
                end
            end
            if (WR_ADDR == ADDR_BG) bg_sh <= rgb332_t'(WR_DATA[7:0]);
        end
    end

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned i = 0; i < NUM_RECT; i++) begin
                x0_act[i]  <= '0;
                x1_act[i]  <= '0;
                y0_act[i]  <= '0;
                y1_act[i]  <= '0;
                en_act[i]  <= 1'b0;
                col_act[i] <= '0;
`ifdef VGA_BLINK_EN
                blink_act[i] <= 1'b0;
`endif
            end
            bg_act <= '0;
        end else if (frame_wrap) begin
            for (int unsigned i = 0; i < NUM_RECT; i++) begin
                x0_act[i]  <= x0_sh[i];
                x1_act[i]  <= x1_sh[i];
                y0_act[i]  <= y0_sh[i];
                y1_act[i]  <= y1_sh[i];
                en_act[i]  <= en_sh[i];
                col_act[i] <= col_sh[i];
`ifdef VGA_BLINK_EN
                blink_act[i] <= blink_sh[i];
`endif
            end
            bg_act <= bg_sh;
        end
    end

`ifdef VGA_BLINK_EN
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N)        frame_cnt <= '0;
        else if (frame_wrap) frame_cnt <= frame_cnt + 6'd1;
    end
`endif

    // ------------------------------------------------------------------
    // Hit test and priority select
    // ------------------------------------------------------------------
    logic [NUM_RECT-1:0] hit;
    logic                hit_found;
    rgb332_t             pix_colour;

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < NUM_RECT; i++) begin
            hit[i] = en_act[i]
                  && (x >= x0_act[i]) && (x <= x1_act[i])
                  && (y >= y0_act[i]) && (y <= y1_act[i]);
`ifdef VGA_BLINK_EN
            if (blink_act[i] && !frame_cnt[5]) hit[i] = 1'b0;
`endif
        end
    end

    always_comb begin
        pix_colour = bg_act;
        hit_found  = 1'b0;
        for (int unsigned i = 0; i < NUM_RECT; i++) begin
            if (!hit_found && hit[i]) begin
                pix_colour = col_act[i];
                hit_found  = 1'b1;
            end
        end
        if (!active) pix_colour = '0;
    end

    // ------------------------------------------------------------------
    // Output pipeline: colour and syncs share both stages
    // ------------------------------------------------------------------
    rgb332_t col_s1;
    rgb332_t col_s2;
    logic    hs_s1;
    logic    hs_s2;
    logic    vs_s1;
    logic    vs_s2;

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            col_s1 <= '0;
            col_s2 <= '0;
            hs_s1  <= 1'b1;
            hs_s2  <= 1'b1;
            vs_s1  <= 1'b1;
            vs_s2  <= 1'b1;
        end else begin
            col_s1 <= pix_colour;
            hs_s1  <= hs_raw;
            vs_s1  <= vs_raw;
            col_s2 <= col_s1;
            hs_s2  <= hs_s1;
            vs_s2  <= vs_s1;
        end
    end

    assign RED    = col_s2.red;
    assign GREEN  = col_s2.green;
    assign BLUE   = col_s2.blue;
    assign h_sync = hs_s2;
    assign v_sync = vs_s2;

    // Upper data bits are don't-care for every register.
    logic unused_wr_data;
    assign unused_wr_data = ^WR_DATA;

endmodule
